shared_resource_arbiter: RTL and testbench

Upstream feeder for the shared doubling resource in the global-stall pipeline. Two pipelines each present a request (valid + 32-bit operand). The block arbitrates them onto the single resource input port and drives the resource's 2-bit one-hot `in_valid` tag, so the response can be steered back to its owner. On a same-cycle conflict it issues the winner, parks the loser in a one-entry holding register, and asserts the global stall for exactly one cycle while the parked request drains.

---
 rtl/shared_res_pkg.sv | 13 +
 rtl/shared_resource_arbiter_if.sv | 24 ++
 rtl/shared_resource_arbiter_rr_pick2.sv | 13 +
 rtl/shared_resource_arbiter.sv | 85 ++++++++
 tb/tb_shared_resource_arbiter.sv | 138 +++++++++++++
 5 files changed

// File: rtl/shared_res_pkg.sv
// Shared definitions for the doubling resource, its arbiter and the response demux.
package shared_res_pkg;
  localparam int DATA_W = 32;
  localparam int REQ_N  = 2;

  typedef logic [REQ_N-1:0] req_tag_t;

  localparam req_tag_t TAG_IDLE = 2'b00;

  function automatic req_tag_t id_to_tag(input logic id);
    return id ? req_tag_t'(2'b10) : req_tag_t'(2'b01);
  endfunction
endpackage

// File: rtl/shared_resource_arbiter_if.sv
// Request/issue bundle between the two pipelines, the arbiter and the resource input.
interface shared_resource_arbiter_if #(parameter int DATA_W = shared_res_pkg::DATA_W);
  import shared_res_pkg::*;

  // Handshake: req_valid[i] is held by pipeline i while stall is high; there is no
  // ready, stall is the only back-pressure. res_valid is a one-hot owner tag with no
  // back-pressure from the resource, and it takes one operand per cycle.
  logic [REQ_N-1:0]  req_valid;
  logic [DATA_W-1:0] req_data0;
  logic [DATA_W-1:0] req_data1;
  logic              stall;
  req_tag_t          res_valid;
  logic [DATA_W-1:0] res_data;

  modport slave (
    input  req_valid, req_data0, req_data1,
    output stall, res_valid, res_data
  );

  modport master (
    output req_valid, req_data0, req_data1,
    input  stall, res_valid, res_data
  );
endinterface

// File: rtl/shared_resource_arbiter_rr_pick2.sv
// Two-way round-robin pick: reports the winner and whether both inputs asked at once.
module rr_pick2 (
  input  logic [1:0] i_req,
  input  logic       i_prio,
  output logic       o_win_id,
  output logic       o_conflict
);
  always_comb begin
    o_conflict = &i_req;
    if (o_conflict) o_win_id = i_prio;
    else            o_win_id = i_req[1];
  end
endmodule

// File: rtl/shared_resource_arbiter.sv
// Arbiter feeding the shared doubling resource; parks a conflict loser for one stall cycle.
// Optional conflict counter compiled in with SHARED_ARB_STATS_EN.
module shared_resource_arbiter
  import shared_res_pkg::*;
#(
  parameter int DATA_W = shared_res_pkg::DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  shared_resource_arbiter_if.slave bus,
`ifdef SHARED_ARB_STATS_EN
  output logic [CNT_W-1:0]     conflict_cnt,
`endif
  output logic [0:0]           o_dbg_state
);
  localparam logic [0:0] ST_ISSUE = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  logic [0:0]        r_state;
  logic              r_pend_id;
  logic [DATA_W-1:0] r_pend_data;
  logic              r_prio;
  req_tag_t          r_res_valid;
  logic [DATA_W-1:0] r_res_data;

  logic w_win_id;
  logic w_conflict;
  logic w_issue_conflict;

  rr_pick2 u_pick (
    .i_req      (bus.req_valid),
    .i_prio     (r_prio),
    .o_win_id   (w_win_id),
    .o_conflict (w_conflict)
  );

  assign w_issue_conflict = (r_state == ST_ISSUE) && w_conflict;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_ISSUE;
      r_pend_id   <= 1'b0;
      r_pend_data <= '0;
      r_prio      <= 1'b0;
      r_res_valid <= TAG_IDLE;
      r_res_data  <= '0;
    end else if (r_state == ST_DRAIN) begin
      // Upstream is stalled; its held request is not a new one.
      r_res_valid <= id_to_tag(r_pend_id);
      r_res_data  <= r_pend_data;
      r_state     <= ST_ISSUE;
    end else if (bus.req_valid != TAG_IDLE) begin
      r_res_valid <= id_to_tag(w_win_id);
      r_res_data  <= w_win_id ? bus.req_data1 : bus.req_data0;
      if (w_conflict) begin
        r_state     <= ST_DRAIN;
        r_pend_id   <= ~r_prio;
        r_pend_data <= r_prio ? bus.req_data0 : bus.req_data1;
        r_prio      <= ~r_prio;
      end
    end else begin
      r_res_valid <= TAG_IDLE;
    end
  end

  assign bus.stall     = (r_state == ST_DRAIN);
  assign bus.res_valid = r_res_valid;
  assign bus.res_data  = r_res_data;
  assign o_dbg_state   = r_state;

`ifdef SHARED_ARB_STATS_EN
  logic [CNT_W-1:0] r_conflict_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                      r_conflict_cnt <= '0;
    else if (w_issue_conflict && !(&r_conflict_cnt)) r_conflict_cnt <= r_conflict_cnt + 1'b1;
  end

  assign conflict_cnt = r_conflict_cnt;
`else
  logic w_unused;
  assign w_unused = w_issue_conflict;
`endif
endmodule

// File: tb/tb_shared_resource_arbiter.sv
// Directed bench for shared_resource_arbiter: vector table plus hand-written corner sequences.
module tb_shared_resource_arbiter;
  import shared_res_pkg::*;

  logic clk;
  logic reset;
  logic [0:0] dbg_state;
  int checks;
  int failures;

  shared_resource_arbiter_if #(.DATA_W(32)) bus ();

`ifdef SHARED_ARB_STATS_EN
  logic [1:0] conflict_cnt;
  shared_resource_arbiter #(.DATA_W(32), .CNT_W(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .conflict_cnt (conflict_cnt),
    .o_dbg_state  (dbg_state)
  );
`else
  shared_resource_arbiter #(.DATA_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );
`endif

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  rv;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  exp_rv;
    logic [31:0] exp_d;
    logic        exp_stall;
  } vec_t;

  vec_t vecs[13];

  // scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver: present a request, clock it in, check the cycle after the edge
  task automatic apply(input string tag, input logic [1:0] rv, input logic [31:0] d0,
                       input logic [31:0] d1, input logic [1:0] exp_rv,
                       input logic [31:0] exp_d, input logic exp_stall);
    bus.req_valid = rv;
    bus.req_data0 = d0;
    bus.req_data1 = d1;
    @(posedge clk);
    #1;
    check({tag, ".res_valid"}, 32'(bus.res_valid), 32'(exp_rv));
    check({tag, ".res_data"},  bus.res_data,        exp_d);
    check({tag, ".stall"},     32'(bus.stall),     32'(exp_stall));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.req_valid = 2'b00;
    bus.req_data0 = '0;
    bus.req_data1 = '0;

    vecs[0]  = '{2'b00, 32'h0,    32'h0,    2'b00, 32'h0,    1'b0};
    vecs[1]  = '{2'b01, 32'h5,    32'h0,    2'b01, 32'h5,    1'b0};
    vecs[2]  = '{2'b10, 32'h0,    32'h7,    2'b10, 32'h7,    1'b0};
    vecs[3]  = '{2'b00, 32'h0,    32'h0,    2'b00, 32'h7,    1'b0};
    vecs[4]  = '{2'b11, 32'hA,    32'hB,    2'b01, 32'hA,    1'b1};
    vecs[5]  = '{2'b11, 32'hA,    32'hB,    2'b10, 32'hB,    1'b0};
    vecs[6]  = '{2'b11, 32'hC,    32'hD,    2'b10, 32'hD,    1'b1};
    vecs[7]  = '{2'b00, 32'h0,    32'h0,    2'b01, 32'hC,    1'b0};
    vecs[8]  = '{2'b11, 32'hE,    32'hF,    2'b01, 32'hE,    1'b1};
    vecs[9]  = '{2'b11, 32'hE,    32'hDEAD, 2'b10, 32'hF,    1'b0};
    vecs[10] = '{2'b10, 32'h0,    32'hDEAD, 2'b10, 32'hDEAD, 1'b0};
    vecs[11] = '{2'b01, 32'h1234, 32'h0,    2'b01, 32'h1234, 1'b0};
    vecs[12] = '{2'b00, 32'h0,    32'h0,    2'b00, 32'h1234, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check("reset.res_valid", 32'(bus.res_valid), 32'(TAG_IDLE));
    check("reset.res_data",  bus.res_data,       32'h0);
    check("reset.stall",     32'(bus.stall),     32'h0);
    check("reset.state",     32'(dbg_state),     32'h0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++)
      apply($sformatf("vec%0d", i), vecs[i].rv, vecs[i].d0, vecs[i].d1,
            vecs[i].exp_rv, vecs[i].exp_d, vecs[i].exp_stall);

`ifdef SHARED_ARB_STATS_EN
    check("cnt_after_3", 32'(conflict_cnt), 32'd3);
`endif

    // two more conflicts push past the 2-bit counter's ceiling
    apply("sat_c4",   2'b11, 32'h1, 32'h2, 2'b10, 32'h2, 1'b1);
    apply("sat_c4_d", 2'b00, 32'h0, 32'h0, 2'b01, 32'h1, 1'b0);
    apply("sat_c5",   2'b11, 32'h3, 32'h4, 2'b01, 32'h3, 1'b1);
    apply("sat_c5_d", 2'b00, 32'h0, 32'h0, 2'b10, 32'h4, 1'b0);
`ifdef SHARED_ARB_STATS_EN
    check("cnt_saturated", 32'(conflict_cnt), 32'd3);
`endif

    // reset while a loser is parked (prio currently 1, so pipeline 1 wins)
    apply("rst_c", 2'b11, 32'h11, 32'h22, 2'b10, 32'h22, 1'b1);
    reset = 1'b1;
    #1;
    check("rst_mid.stall",     32'(bus.stall),     32'h0);
    check("rst_mid.res_valid", 32'(bus.res_valid), 32'h0);
    check("rst_mid.res_data",  bus.res_data,       32'h0);
`ifdef SHARED_ARB_STATS_EN
    check("rst_mid.cnt", 32'(conflict_cnt), 32'd0);
`endif
    #2;
    reset = 1'b0;
    apply("post_rst_c", 2'b11, 32'h5, 32'h6, 2'b01, 32'h5, 1'b1);
    apply("post_rst_d", 2'b00, 32'h0, 32'h0, 2'b10, 32'h6, 1'b0);
    apply("post_rst_i", 2'b00, 32'h0, 32'h0, 2'b00, 32'h6, 1'b0);
`ifdef SHARED_ARB_STATS_EN
    check("post_rst.cnt", 32'(conflict_cnt), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
